// File: rtl/ula_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters; result returned 2 edges after the grant edge.
// Readies stay low outside IDLE; a stalled response (rsp_ready=0) holds the FSM in RESP with data/id stable.
module ula_arbiter #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [OPW-1:0]   alu_ctrl,
   output logic [WIDTH-1:0] alu_scr0,
   output logic [WIDTH-1:0] alu_scr1,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy,
   output logic [15:0]      done_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   logic [1:0]       r_state;
   logic             r_last;
   req_t             r_req;
   logic             r_id;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_id;
   logic [15:0]      r_done_cnt;

   logic             w_idle;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   req_t             w_sel;

   // r_last holds the id granted last; on a tie the other requester wins
   assign w_idle   = (r_state == ST_IDLE);
   assign w_gnt1   = req1_valid & (~req0_valid | ~r_last);
   assign w_gnt0   = req0_valid & ~w_gnt1;
   assign w_accept = w_idle & (w_gnt0 | w_gnt1);
   assign w_sel    = w_gnt1 ? req_t'{req1_op, req1_a, req1_b}
                            : req_t'{req0_op, req0_a, req0_b};

   assign req0_ready = w_idle & w_gnt0;
   assign req1_ready = w_idle & w_gnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_last      <= 1'b1;
         r_req       <= '0;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= 1'b0;
         r_done_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_req   <= w_sel;
                  r_id    <= w_gnt1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rsp_data  <= alu_result;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_last      <= r_rsp_id;
                  if (r_done_cnt != 16'hFFFF) begin
                     r_done_cnt <= r_done_cnt + 16'd1;
                  end
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign alu_ctrl  = r_req.op;
   assign alu_scr0  = r_req.a;
   assign alu_scr1  = r_req.b;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign busy      = ~w_idle;
   assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter with a behavioural ALU on the result input.
module tb_ula_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_ready;
   logic [2:0] req0_op;
   logic [7:0] req0_a, req0_b;
   logic       req1_valid, req1_ready;
   logic [2:0] req1_op;
   logic [7:0] req1_a, req1_b;
   logic [2:0] alu_ctrl;
   logic [7:0] alu_scr0, alu_scr1, alu_result;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_id;
   logic       busy;
   logic [15:0] done_cnt;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   int   hs_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   ula_arbiter #(.WIDTH(8), .OPW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctrl(alu_ctrl), .alu_scr0(alu_scr0), .alu_scr1(alu_scr1),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .busy(busy), .done_cnt(done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ula_simples behaviour
   always_comb begin
      case (alu_ctrl)
         3'b111:  alu_result = alu_scr0 | alu_scr1;
         3'b110:  alu_result = alu_scr0 & alu_scr1;
         3'b101:  alu_result = alu_scr0 - alu_scr1;
         3'b100:  alu_result = alu_scr0 + alu_scr1;
         default: alu_result = alu_scr0 + 8'd1;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // monitor: pops one expectation per response handshake
   always @(negedge clk) begin
      if (rst_n) begin
         chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp actual id=%0d data=%0h expected none", rsp_id, rsp_data);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
               chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            end
         end
      end
   end

   task automatic drive(input int n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int k;
      @(posedge clk);
      #1;
      if (n == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
      k = 0;
      forever begin
         @(negedge clk);
         if ((n == 0) ? req0_ready : req1_ready) break;
         k++;
         if (k > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout actual=no_ready expected=ready req%0d", n);
            break;
         end
      end
      hs_q.push_back(cyc);
      @(posedge clk);
      #1;
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
         k++;
         if (k > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout actual=pending%0d expected=0", exp_q.size());
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {29'd0, alu_ctrl}, 0);
      chk("rst_scr0", {24'd0, alu_scr0}, 0);
      chk("rst_scr1", {24'd0, alu_scr1}, 0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rsp_data", {24'd0, rsp_data}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {16'd0, done_cnt}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // first transaction: ADD 5+3 with latency checks
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_op = 3'b100; req0_a = 8'h05; req0_b = 8'h03; rsp_ready = 1'b1;
      exp_q.push_back('{1'b0, 8'h08});
      @(negedge clk);
      chk("t1_rdy0", {31'd0, req0_ready}, 1);
      chk("t1_rdy1", {31'd0, req1_ready}, 0);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      chk("t1_exec_busy", {31'd0, busy}, 1);
      chk("t1_exec_rspv", {31'd0, rsp_valid}, 0);
      chk("t1_ctrl", {29'd0, alu_ctrl}, 32'h4);
      chk("t1_scr0", {24'd0, alu_scr0}, 32'h05);
      chk("t1_scr1", {24'd0, alu_scr1}, 32'h03);
      @(negedge clk);
      chk("t1_rspv", {31'd0, rsp_valid}, 1);
      @(negedge clk);
      chk("t1_done", {16'd0, done_cnt}, 1);
      chk("t1_idle", {31'd0, busy}, 0);
      chk("t1_hold_ctrl", {29'd0, alu_ctrl}, 32'h4);

      // wrap cases back-to-back on one requester
      exp_q.push_back('{1'b0, 8'hFF});
      exp_q.push_back('{1'b0, 8'h00});
      exp_q.push_back('{1'b0, 8'h80});
      exp_q.push_back('{1'b0, 8'h00});
      hs_q.delete();
      drive(0, 3'b101, 8'h00, 8'h01);
      drive(0, 3'b100, 8'hFF, 8'h01);
      drive(0, 3'b000, 8'h7F, 8'h55);
      drive(0, 3'b011, 8'hFF, 8'h12);
      wait_drain();
      for (int i = 1; i < 4; i++) chk("b2b_interval", hs_q[i] - hs_q[i-1], 3);
      chk("wrap_done", {16'd0, done_cnt}, 5);

      // backpressure
      @(posedge clk); #1 rsp_ready = 1'b0;
      exp_q.push_back('{1'b1, 8'h32});
      exp_q.push_back('{1'b0, 8'h5A});
      drive(1, 3'b100, 8'h10, 8'h22);
      req0_valid = 1'b1; req0_op = 3'b111; req0_a = 8'h0A; req0_b = 8'h50;
      begin
         int k;
         k = 0;
         while (k < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            k++;
         end
         chk("bp_rspv_seen", {31'd0, rsp_valid}, 1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data", {24'd0, rsp_data}, 32'h32);
         chk("bp_id", {31'd0, rsp_id}, 1);
         chk("bp_busy", {31'd0, busy}, 1);
         chk("bp_rdy0", {31'd0, req0_ready}, 0);
         chk("bp_rdy1", {31'd0, req1_ready}, 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_busy", {31'd0, busy}, 1);
      @(negedge clk);
      chk("bp_idle", {31'd0, busy}, 0);
      chk("bp_next_grant", {31'd0, req0_ready}, 1);
      @(posedge clk); #1 req0_valid = 1'b0;
      wait_drain();
      chk("bp_done", {16'd0, done_cnt}, 7);

      // reset during EXEC of a req1 SUB
      drive(1, 3'b101, 8'h09, 8'h04);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_ctrl", {29'd0, alu_ctrl}, 0);
      chk("mr_scr0", {24'd0, alu_scr0}, 0);
      chk("mr_scr1", {24'd0, alu_scr1}, 0);
      chk("mr_rspv", {31'd0, rsp_valid}, 0);
      chk("mr_busy", {31'd0, busy}, 0);
      chk("mr_done", {16'd0, done_cnt}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mr_no_rsp", {31'd0, rsp_valid}, 0);
      end

      // fairness: both requesters continuous, req0 wins first tie after reset
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{1'b0, 8'hFF});
         exp_q.push_back('{1'b1, 8'h30});
      end
      fork
         begin
            for (int i = 0; i < 3; i++) drive(0, 3'b111, 8'hF0, 8'h0F);
         end
         begin
            for (int j = 0; j < 3; j++) drive(1, 3'b110, 8'hF0, 8'h3C);
         end
      join
      wait_drain();
      chk("rr_done", {16'd0, done_cnt}, 6);

      // saturation of the completion counter
      @(posedge clk); #1;
      force dut.r_done_cnt = 16'hFFFE;
      #1 release dut.r_done_cnt;
      @(negedge clk);
      chk("sat_preload", {16'd0, done_cnt}, 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{1'b0, 8'h31 + 8'(i)});
         drive(0, 3'b000, 8'h30 + 8'(i), 8'h00);
         wait_drain();
         chk("sat_cnt", {16'd0, done_cnt}, 32'hFFFF);
      end

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
